glyph_row_scheduler: RTL and testbench
======================================

# glyph_row_scheduler

Sequences the shared 3x5 digit-glyph lookup for the memory-game display and arbitrates it among several digit requesters. Grants one requester at a time using round-robin priority. Drives the granted digit onto the lookup, captures the returned 15-bit glyph, and streams it as five 3-pixel rows to the display driver over a valid/ready handshake. Sits between the game-logic digit sources and the LED/VGA row driver.

## Interface
- NUM_SLOTS, 4: number of requesters; legal range 2..8.
- SLOT_W, $clog2(NUM_SLOTS): width of the slot index.

- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_SLOTS  per-slot render request; the requester holds it high until its grant bit is seen.
- digit  in  4*NUM_SLOTS  per-slot digit code; slot i occupies bits [4i+3:4i]; stable while req[i] is high.
- grant  out  NUM_SLOTS  one-hot; high for exactly one cycle when a slot is accepted.
- glyph_num  out  4  digit code driven to the glyph lookup.
- glyph_seq  in  15  combinational glyph from the lookup; bits [14:12] are the top row, [2:0] the bottom row.
- row_valid  out  1  row_data, row_idx and row_slot are valid.
- row_ready  in  1  display driver accepts the row.
- row_data  out  3  row pixels; bit 2 is the leftmost pixel.
- row_idx  out  3  row number 0..4, where 0 is the top row.
- row_slot  out  SLOT_W  slot that owns the current glyph.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after row 4 is accepted.

## Operation
- FSM has four states: IDLE, LOOKUP, EMIT, DONE.
- IDLE:
  - If req is nonzero, select the first set bit found searching upward from the priority pointer ptr, wrapping at NUM_SLOTS.
  - Register that slot's digit into the digit latch, set grant[sel], set row_slot = sel, go to LOOKUP.
  - If req is zero, stay in IDLE.
- LOOKUP (one cycle):
  - glyph_num = latched digit; grant is high in this cycle only.
  - Capture glyph_seq into the glyph register, clear the row counter, go to EMIT.
- EMIT:
  - row_valid = 1; row_data = glyph register bits [14-3r : 12-3r], where r = row counter; row_idx = r.
  - On row_valid && row_ready: if r == 4, go to DONE, otherwise r increments.
  - Outputs hold stable while row_ready is low; no timeout.
- DONE (one cycle):
  - done = 1; ptr = (row_slot + 1) mod NUM_SLOTS; go to IDLE.
- glyph_num holds the latched digit from LOOKUP through DONE, and 0 in IDLE.
- Digit codes 10..15 are not filtered. Whatever the lookup returns (all-zero) is streamed as five blank rows, with done as normal.
- Requests that arrive while busy are ignored until IDLE. A req bit that drops before its grant is simply not served.

## Timing
- Reset values: state IDLE, ptr 0, grant 0, glyph_num 0, row_valid 0, row_data 0, row_idx 0, row_slot 0, busy 0, done 0, glyph register 0.
- Sequence with req[i] first high in IDLE at cycle t:
  - t+1: grant[i] and LOOKUP.
  - t+2: first row_valid.
  - With row_ready held high, rows are emitted at t+2..t+6.
  - t+7: done.
  - t+8: IDLE, which can sample the next req; the next grant is at t+9.
- Minimum glyph period is 8 cycles. Each cycle with row_ready low adds one cycle.
- All outputs are registered or decoded from registered state only; there is no combinational path from req or row_ready to outputs.
- The glyph is sampled once, in LOOKUP. A glyph_seq change during EMIT has no effect.
- If rst_n is asserted mid-glyph, the transfer is aborted immediately: no done, ptr returns to 0. After release, operation restarts from IDLE.
- ptr is updated only in DONE, so a slot that is never granted keeps its position in the rotation.

## Test plan
- Reset, then req=0001, digit0=2 (lookup returns 111001111100111), row_ready=1 -> grant=0001 at t+1; rows 7,1,7,4,7 with row_idx 0..4 at t+2..t+6; done at t+7.
- req=1111 held continuously, with each requester dropping its req after its grant and re-raising it at the next IDLE -> grants come in order 0001, 0010, 0100, 1000, 0001, each 8 cycles apart.
- Render digit 8, with row_ready low for 3 cycles at row 2 -> row_data and row_idx hold at row 2 throughout the stall; done is delayed 3 cycles; no row is lost or duplicated.
- digit=4'hC on slot 3 -> five rows of 000 with row_slot=3, then done; ptr advances to 0.
- Assert rst_n low during EMIT row 3 -> all outputs go to 0 immediately, no done pulse; the next request after release is granted by priority from slot 0.
- Change glyph_seq and digit during EMIT -> emitted rows still match the glyph captured in LOOKUP.

Source files
------------

// File: rtl/glyph_row_scheduler.sv
// Round-robin arbiter for the shared 3x5 digit-glyph lookup; streams the captured
// glyph to the display driver as five 3-pixel rows over a valid/ready handshake.
module glyph_row_scheduler #(
    parameter int NUM_SLOTS = 4,
    parameter int SLOT_W    = $clog2(NUM_SLOTS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_SLOTS-1:0]   req,
    input  logic [4*NUM_SLOTS-1:0] digit,
    output logic [NUM_SLOTS-1:0]   grant,
    output logic [3:0]             glyph_num,
    input  logic [14:0]            glyph_seq,
    output logic                   row_valid,
    input  logic                   row_ready,
    output logic [2:0]             row_data,
    output logic [2:0]             row_idx,
    output logic [SLOT_W-1:0]      row_slot,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [1:0] {IDLE, LOOKUP, EMIT, DONE} state_t;

    state_t                state_reg, state_next;
    logic [SLOT_W-1:0]     ptr_reg, ptr_next;
    logic [SLOT_W-1:0]     slot_reg, slot_next;
    logic [3:0]            digit_reg, digit_next;
    logic [14:0]           glyph_reg, glyph_next;
    logic [2:0]            row_reg, row_next;
    logic [NUM_SLOTS-1:0]  grant_reg, grant_next;

    logic [3:0]            digit_arr [NUM_SLOTS];
    logic [SLOT_W-1:0]     sel;
    logic                  sel_valid;
    logic [SLOT_W:0]       idx;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            assign digit_arr[gi] = digit[4*gi +: 4];
        end
    endgenerate

    // Scan from the highest offset down so the slot closest above ptr wins.
    always_comb begin
        sel       = '0;
        sel_valid = 1'b0;
        idx       = '0;
        for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
            idx = {1'b0, ptr_reg} + (SLOT_W+1)'(k);
            if (idx >= (SLOT_W+1)'(NUM_SLOTS))
                idx = idx - (SLOT_W+1)'(NUM_SLOTS);
            if (req[idx[SLOT_W-1:0]]) begin
                sel       = idx[SLOT_W-1:0];
                sel_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            slot_reg  <= '0;
            digit_reg <= '0;
            glyph_reg <= '0;
            row_reg   <= '0;
            grant_reg <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            slot_reg  <= slot_next;
            digit_reg <= digit_next;
            glyph_reg <= glyph_next;
            row_reg   <= row_next;
            grant_reg <= grant_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        slot_next  = slot_reg;
        digit_next = digit_reg;
        glyph_next = glyph_reg;
        row_next   = row_reg;
        grant_next = '0;
        case (state_reg)
            IDLE: begin
                if (sel_valid) begin
                    digit_next      = digit_arr[sel];
                    grant_next[sel] = 1'b1;
                    slot_next       = sel;
                    state_next      = LOOKUP;
                end
            end
            LOOKUP: begin
                glyph_next = glyph_seq;
                row_next   = '0;
                state_next = EMIT;
            end
            EMIT: begin
                if (row_ready) begin
                    if (row_reg == 3'd4)
                        state_next = DONE;
                    else
                        row_next = row_reg + 3'd1;
                end
            end
            DONE: begin
                if (slot_reg == SLOT_W'(NUM_SLOTS - 1))
                    ptr_next = '0;
                else
                    ptr_next = slot_reg + SLOT_W'(1);
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs decode from registered state only; nothing combinational from req/row_ready.
    always_comb begin
        row_data = 3'b000;
        if (state_reg == EMIT) begin
            case (row_reg)
                3'd0:    row_data = glyph_reg[14:12];
                3'd1:    row_data = glyph_reg[11:9];
                3'd2:    row_data = glyph_reg[8:6];
                3'd3:    row_data = glyph_reg[5:3];
                3'd4:    row_data = glyph_reg[2:0];
                default: row_data = 3'b000;
            endcase
        end
    end

    assign grant     = grant_reg;
    assign glyph_num = (state_reg == IDLE) ? 4'd0 : digit_reg;
    assign row_valid = (state_reg == EMIT);
    assign row_idx   = (state_reg == EMIT) ? row_reg : 3'd0;
    assign row_slot  = slot_reg;
    assign busy      = (state_reg != IDLE);
    assign done      = (state_reg == DONE);

endmodule

// File: tb/tb_glyph_row_scheduler.sv
// Directed bench for glyph_row_scheduler: rendering, round-robin order, stalls,
// blank glyphs, mid-glyph reset and glyph capture timing.
module tb_glyph_row_scheduler;

    localparam int NUM_SLOTS = 4;
    localparam int SLOT_W    = 2;

    logic                   clk;
    logic                   rst_n;
    logic [NUM_SLOTS-1:0]   req;
    logic [4*NUM_SLOTS-1:0] digit;
    logic [NUM_SLOTS-1:0]   grant;
    logic [3:0]             glyph_num;
    logic [14:0]            glyph_seq;
    logic                   row_valid;
    logic                   row_ready;
    logic [2:0]             row_data;
    logic [2:0]             row_idx;
    logic [SLOT_W-1:0]      row_slot;
    logic                   busy;
    logic                   done;

    logic                   glyph_force;
    logic [14:0]            glyph_force_val;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int fail_cnt  = 0;

    glyph_row_scheduler #(.NUM_SLOTS(NUM_SLOTS), .SLOT_W(SLOT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .digit     (digit),
        .grant     (grant),
        .glyph_num (glyph_num),
        .glyph_seq (glyph_seq),
        .row_valid (row_valid),
        .row_ready (row_ready),
        .row_data  (row_data),
        .row_idx   (row_idx),
        .row_slot  (row_slot),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [14:0] glyph_lut(input logic [3:0] d);
        case (d)
            4'd0:    return 15'b111_101_101_101_111;
            4'd1:    return 15'b010_110_010_010_111;
            4'd2:    return 15'b111_001_111_100_111;
            4'd3:    return 15'b111_001_111_001_111;
            4'd4:    return 15'b101_101_111_001_001;
            4'd5:    return 15'b111_100_111_001_111;
            4'd6:    return 15'b111_100_111_101_111;
            4'd7:    return 15'b111_001_001_001_001;
            4'd8:    return 15'b111_101_111_101_111;
            4'd9:    return 15'b111_101_111_001_111;
            default: return 15'b0;
        endcase
    endfunction

    assign glyph_seq = glyph_force ? glyph_force_val : glyph_lut(glyph_num);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, " grant"},     32'(grant),     32'd0);
        chk({tag, " glyph_num"}, 32'(glyph_num), 32'd0);
        chk({tag, " row_valid"}, 32'(row_valid), 32'd0);
        chk({tag, " row_data"},  32'(row_data),  32'd0);
        chk({tag, " row_idx"},   32'(row_idx),   32'd0);
        chk({tag, " row_slot"},  32'(row_slot),  32'd0);
        chk({tag, " busy"},      32'(busy),      32'd0);
        chk({tag, " done"},      32'(done),      32'd0);
    endtask

    // One full glyph: request, grant check, five rows (optional stall), done.
    task automatic render(input string name, input logic [3:0] mask, input int slot,
                          input logic [3:0] d, input logic [14:0] g,
                          input int stall_row, input int stall_len, input bit perturb);
        logic [2:0] exp_row;
        digit[4*slot +: 4] = d;
        req = mask;
        step();
        $display("%s: grant=%b slot=%0d digit=%0h", name, grant, slot, d);
        chk({name, " grant"},     32'(grant),     32'(1) << slot);
        chk({name, " lookup num"}, 32'(glyph_num), 32'(d));
        chk({name, " lookup valid"}, 32'(row_valid), 32'd0);
        req = '0;
        step();
        if (perturb) begin
            glyph_force     = 1'b1;
            glyph_force_val = ~g;
            digit[4*slot +: 4] = ~d;
        end
        for (int r = 0; r < 5; r++) begin
            exp_row = g[14 - 3*r -: 3];
            chk({name, " row_valid"}, 32'(row_valid), 32'd1);
            chk({name, " row_data"},  32'(row_data),  32'(exp_row));
            chk({name, " row_idx"},   32'(row_idx),   32'(r));
            chk({name, " row_slot"},  32'(row_slot),  32'(slot));
            chk({name, " emit num"},  32'(glyph_num), 32'(d));
            if (r == stall_row) begin
                row_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    step();
                    chk({name, " stall data"}, 32'(row_data), 32'(exp_row));
                    chk({name, " stall idx"},  32'(row_idx),  32'(r));
                    chk({name, " stall done"}, 32'(done),     32'd0);
                end
                row_ready = 1'b1;
            end
            step();
        end
        chk({name, " done"},       32'(done),      32'd1);
        chk({name, " done valid"}, 32'(row_valid), 32'd0);
        chk({name, " done busy"},  32'(busy),      32'd1);
        step();
        chk({name, " done clear"}, 32'(done),      32'd0);
        chk({name, " idle busy"},  32'(busy),      32'd0);
        chk({name, " idle num"},   32'(glyph_num), 32'd0);
        glyph_force = 1'b0;
    endtask

    initial begin
        rst_n           = 1'b0;
        req             = '0;
        digit           = '0;
        row_ready       = 1'b1;
        glyph_force     = 1'b0;
        glyph_force_val = '0;

        // Reset state
        #2;
        chk_idle_zero("reset");
        step();
        rst_n = 1'b1;
        step();

        // Digit 2 on slot 0, rows 7,1,7,4,7
        render("digit2", 4'b0001, 0, 4'd2, 15'b111_001_111_100_111, -1, 0, 1'b0);

        // Reset to bring ptr back to 0 before the rotation check
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        // Round robin with all requesters active
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step();
            $display("rr %0d: grant=%b", k, grant);
            chk("rr grant", 32'(grant), 32'(1) << (k % 4));
            req[k % 4] = 1'b0;
            for (int c = 0; c < 7; c++) step();
            chk("rr idle", 32'(busy), 32'd0);
            req[k % 4] = 1'b1;
            if (k == 4) req = '0;
        end
        step();
        chk("rr quiet", 32'(busy), 32'd0);

        // ptr = 1: digit 8 on slot 1 with a 3-cycle stall at row 2
        render("stall8", 4'b0010, 1, 4'd8, 15'b111_101_111_101_111, 2, 3, 1'b0);

        // ptr = 2: abort slot 2 during row 3
        digit[11:8] = 4'd5;
        req = 4'b0100;
        step();
        chk("abort grant", 32'(grant), 32'b0100);
        req = '0;
        step();
        step();
        step();
        step();
        chk("abort row3 idx", 32'(row_idx), 32'd3);
        chk("abort row3 data", 32'(row_data), 32'b001);
        rst_n = 1'b0;
        #1;
        $display("abort: busy=%b row_valid=%b", busy, row_valid);
        chk_idle_zero("abort");
        step();
        chk("abort no done", 32'(done), 32'd0);
        rst_n = 1'b1;
        step();

        // ptr must be 0 again: slots 0,1,3 requesting -> slot 0
        render("after abort", 4'b1011, 0, 4'd1, 15'b010_110_010_010_111, -1, 0, 1'b0);

        // ptr = 1: invalid digit on slot 3 streams blank rows
        render("digitC", 4'b1000, 3, 4'hC, 15'b0, -1, 0, 1'b0);

        // ptr wrapped to 0: slots 0 and 3 requesting -> slot 0
        render("wrap", 4'b1001, 0, 4'd7, 15'b111_001_001_001_001, -1, 0, 1'b0);

        // Glyph and digit changed during EMIT must not affect rows
        render("capture", 4'b0100, 2, 4'd3, 15'b111_001_111_001_111, -1, 0, 1'b1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
